// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional misaligned-PC handling is enabled with FETCH_MISALIGN_EN.
package fetch_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000;

  function automatic logic pc_aligned(input logic [63:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction FIFO; flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush && ((count_q != DEPTH_C) || pop);
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while head_valid is set.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues one ibus request at a time under FIFO
// credit, and discards responses made stale by a redirect. Misaligned
// redirect targets are reported instead of fetched when FETCH_MISALIGN_EN is set.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          req_valid_q, req_valid_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic          drop_q, drop_d;
`ifdef FETCH_MISALIGN_EN
  logic          parked_q, parked_d;
`endif

  logic          fifo_push, fifo_pop, fifo_valid;
  fetch_entry_t  fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count, count_after_pop, count_next;
  logic          rsp_fire, issue, credit, tgt_ok;
  logic [63:0]   redirect_tgt;
  logic          unused_bits;

`ifdef FETCH_MISALIGN_EN
  assign redirect_tgt = redirect_pc;
  assign unused_bits  = iresp.addr_ok;
`else
  assign redirect_tgt = {redirect_pc[63:2], 2'b00};
  assign unused_bits  = ^{iresp.addr_ok, redirect_pc[1:0], fifo_head.misalign};
`endif

  assign fifo_pop = fifo_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    drop_d      = drop_q;
    fifo_push   = 1'b0;
    fifo_wdata  = '{pc: pc_q, instr: iresp.data, misalign: 1'b0};
    issue       = 1'b0;
`ifdef FETCH_MISALIGN_EN
    parked_d    = parked_q;
`endif

    rsp_fire        = (state_q == ST_WAIT) && iresp.data_ok;
    count_after_pop = fifo_count - CW'(fifo_pop);

    if (rsp_fire && !drop_q && !redirect_valid) fifo_push = 1'b1;

`ifdef FETCH_MISALIGN_EN
    // A misaligned PC becomes one marker entry, then fetch parks until redirected.
    if ((state_q == ST_IDLE) && !redirect_valid && !pc_aligned(pc_q) && !parked_q &&
        (count_after_pop < DEPTH_C)) begin
      fifo_push  = 1'b1;
      fifo_wdata = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
      parked_d   = 1'b1;
    end
`endif

    count_next = redirect_valid ? '0 : (count_after_pop + CW'(fifo_push));
    credit     = count_next < DEPTH_C;

    if (redirect_valid) begin
      pc_d = redirect_tgt;
`ifdef FETCH_MISALIGN_EN
      parked_d = 1'b0;
`endif
      if ((state_q == ST_WAIT) && !iresp.data_ok) begin
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b0;
        issue  = 1'b1;
      end
    end else if (state_q == ST_WAIT) begin
      if (iresp.data_ok) begin
        drop_d = 1'b0;
        if (!drop_q) pc_d = pc_q + 64'd4;
        issue = 1'b1;
      end
    end else begin
      issue = 1'b1;
    end

`ifdef FETCH_MISALIGN_EN
    tgt_ok = pc_aligned(pc_d);
`else
    tgt_ok = 1'b1;
`endif

    if (issue) begin
      if (credit && tgt_ok) begin
        state_d     = ST_WAIT;
        req_valid_d = 1'b1;
        req_addr_d  = pc_d;
      end else begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      drop_q      <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      parked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
`ifdef FETCH_MISALIGN_EN
      parked_q    <= parked_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_valid(fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign ireq.valid = req_valid_q;
  assign ireq.addr  = req_addr_q;
  assign out_valid  = fifo_valid;
  assign out_pc     = fifo_head.pc;
  assign out_instr  = fifo_head.instr;
`ifdef FETCH_MISALIGN_EN
  assign out_misalign = fifo_head.misalign;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable cache model feeds
// responses and a scoreboard queue holds the instruction stream decode should see.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_EN
  logic        out_misalign;
`endif

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [63:0] exp_pc;
  logic        stale;
  int          lat;
  int          wait_cnt;
  int          dok_cnt;
  logic        use_dead;
  logic        prev_valid, prev_dok;
  logic [63:0] prev_addr;

  fetch_stage #(
    .RESET_PC(64'h0000_0000_8000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq          (ireq),
    .iresp         (iresp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
`ifdef FETCH_MISALIGN_EN
    ,
    .out_misalign  (out_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return use_dead ? 32'hDEAD_BEEF : (a[31:0] ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: score what the DUT shows, then drive this cycle's inputs.
  task automatic cyc(input logic redir, input logic [63:0] rpc);
    logic dok;
    exp_t e;
    dok = ireq.valid && (wait_cnt >= lat);
    if (prev_valid && !prev_dok) begin
      chk("hold_valid", 64'(ireq.valid), 64'd1);
      chk("hold_addr", ireq.addr, prev_addr);
    end
    iresp.addr_ok  = ireq.valid;
    iresp.data_ok  = dok;
    iresp.data     = dok ? instr_of(ireq.addr) : 32'h0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_out observed=%h expected=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", 64'(out_instr), 64'(e.instr));
`ifdef FETCH_MISALIGN_EN
        chk("out_misalign", 64'(out_misalign), 64'(e.mis));
`endif
      end
    end
    if (dok) begin
      dok_cnt++;
      if (!stale) begin
        chk("req_addr", ireq.addr, exp_pc);
        if (!redir) exp_q.push_back('{pc: exp_pc, instr: instr_of(exp_pc), mis: 1'b0});
        exp_pc = exp_pc + 64'd4;
      end
      stale = 1'b0;
    end
    if (redir) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_EN
      exp_pc = rpc;
`else
      exp_pc = {rpc[63:2], 2'b00};
`endif
      if (ireq.valid && !dok) stale = 1'b1;
    end
    wait_cnt   = (dok || !ireq.valid) ? 0 : wait_cnt + 1;
    prev_valid = ireq.valid;
    prev_addr  = ireq.addr;
    prev_dok   = dok;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp          = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(ireq.valid), 64'd0);
    chk("rst_addr", ireq.addr, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    exp_pc     = 64'h0000_0000_8000_0000;
    stale      = 1'b0;
    wait_cnt   = 0;
    prev_valid = 1'b0;
    prev_dok   = 1'b0;
    prev_addr  = '0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    out_ready = 1'b0;
    lat       = 0;
    dok_cnt   = 0;
    use_dead  = 1'b0;

    // Back-to-back hits with decode always ready.
    out_ready = 1'b1;
    do_reset();
    chk("first_req_valid", 64'(ireq.valid), 64'd1);
    chk("first_req_addr", ireq.addr, 64'h8000_0000);
    cyc(1'b0, '0);
    chk("out_lat_valid", 64'(out_valid), 64'd1);
    chk("out_lat_pc", out_pc, 64'h8000_0000);
    d0 = dok_cnt;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0);
    chk("b2b_responses", 64'(dok_cnt - d0), 64'd3);
    chk("b2b_addr", ireq.addr, 64'h8000_0010);

    // Decode stalled: exactly two entries, then fetch stops until a slot frees.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, '0);
    chk("full_req_idle", 64'(ireq.valid), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_out_pc", out_pc, 64'h8000_0000);
    chk("full_entries", 64'(exp_q.size()), 64'd2);
    out_ready = 1'b1;
    cyc(1'b0, '0);
    chk("reissue_valid", 64'(ireq.valid), 64'd1);
    chk("reissue_addr", ireq.addr, 64'h8000_0008);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);

    // Slow cache: request held for three wait cycles, then DEADBEEF delivered.
    lat      = 3;
    use_dead = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0);
    chk("slow_out_valid", 64'(out_valid), 64'd1);
    chk("slow_out_instr", 64'(out_instr), 64'hDEAD_BEEF);
    chk("slow_out_pc", out_pc, 64'h8000_0000);
    use_dead = 1'b0;

    // Redirect while 0x80000004 is outstanding: its response must vanish.
    chk("pre_redir_addr", ireq.addr, 64'h8000_0004);
    cyc(1'b1, 64'h8000_1000);
    for (int i = 0; i < 10 && stale; i++) cyc(1'b0, '0);
    chk("drop_resolved", 64'(stale), 64'd0);
    chk("redir_req_valid", 64'(ireq.valid), 64'd1);
    chk("redir_req_addr", ireq.addr, 64'h8000_1000);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);

    // Redirect coinciding with data_ok and a head handshake.
    lat = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0);
    chk("same_pre_out_valid", 64'(out_valid), 64'd1);
    chk("same_pre_req_valid", 64'(ireq.valid), 64'd1);
    cyc(1'b1, 64'h8000_3000);
    chk("same_flush_empty", 64'(out_valid), 64'd0);
    chk("same_req_valid", 64'(ireq.valid), 64'd1);
    chk("same_req_addr", ireq.addr, 64'h8000_3000);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0);

`ifdef FETCH_MISALIGN_EN
    // Misaligned target: no ibus traffic, one marker entry, then parked.
    cyc(1'b1, 64'h8000_5002);
    exp_q.push_back('{pc: 64'h8000_5002, instr: 32'h0000_0013, mis: 1'b1});
    chk("mis_req_idle", 64'(ireq.valid), 64'd0);
    cyc(1'b0, '0);
    chk("mis_out_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_pc", out_pc, 64'h8000_5002);
    chk("mis_instr", 64'(out_instr), 64'h0000_0013);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("mis_parked_req", 64'(ireq.valid), 64'd0);
    chk("mis_parked_out", 64'(out_valid), 64'd0);
`else
    // Low PC bits are ignored on redirect.
    cyc(1'b1, 64'h8000_6002);
    chk("align_req_valid", 64'(ireq.valid), 64'd1);
    chk("align_req_addr", ireq.addr, 64'h8000_6000);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
